// File: rtl/econ_v0_encoder.sv
// ECON front-end encoder: 48 inputs -> 3 latents.
// Each latent is ReLU(floor(mean of a 16-element group)).
module econ_v0_encoder #(
  parameter int W     = 18,
  parameter int N_IN  = 48,
  parameter int N_OUT = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_IN*W-1:0]     input_48_rsc_dat,
  input  logic                  input_48_rsc_vld,
  output logic                  input_48_rsc_rdy,
  output logic                  input_48_rsc_triosy_lz,
  output logic [N_OUT*W-1:0]    layer7_out_rsc_dat,
  output logic                  layer7_out_rsc_vld,
  input  logic                  layer7_out_rsc_rdy,
  output logic                  layer7_out_rsc_triosy_lz,
  output logic [15:0]           const_size_in_1_rsc_dat,
  output logic                  const_size_in_1_rsc_vld,
  output logic                  const_size_in_1_rsc_triosy_lz,
  output logic [15:0]           const_size_out_1_rsc_dat,
  output logic                  const_size_out_1_rsc_vld,
  output logic                  const_size_out_1_rsc_triosy_lz
);

  localparam int G  = N_IN / N_OUT;
  localparam int KW = $clog2(G);
  localparam int AW = W + KW;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    OUT
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;

  logic [N_IN*W-1:0]     r_in;
  logic signed [AW-1:0]  r_acc [N_OUT];
  logic [KW-1:0]         r_k;
  logic                  r_rdy;
  logic                  r_vld;
  logic                  r_cvld;
  logic                  r_in_tri;
  logic                  r_out_tri;
  logic [N_OUT*W-1:0]    r_dat;

  logic signed [W-1:0]   w_elem    [N_OUT];
  logic signed [AW-1:0]  w_acc_nxt [N_OUT];
  logic [N_OUT*W-1:0]    w_dat_nxt;
  logic                  w_in_fire;
  logic                  w_out_fire;
  logic                  w_last;

  assign w_in_fire  = (r_state == IDLE) && r_rdy
                    && input_48_rsc_vld;
  assign w_out_fire = (r_state == OUT) && r_vld
                    && layer7_out_rsc_rdy;
  assign w_last     = (r_k == KW'(G - 1));

  // element k of every group is added in the same cycle
  always_comb begin
    w_dat_nxt = '0;
    for (int j = 0; j < N_OUT; j++) begin
      w_elem[j]    = r_in[(j*G + int'(r_k))*W +: W];
      w_acc_nxt[j] = r_acc[j]
                   + {{(AW-W){w_elem[j][W-1]}}, w_elem[j]};
      if (!w_acc_nxt[j][AW-1])
        w_dat_nxt[j*W +: W] = w_acc_nxt[j][AW-1:KW];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_in_fire)  w_state_nxt = CALC;
      CALC:    if (w_last)     w_state_nxt = OUT;
      OUT:     if (w_out_fire) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_rdy   <= 1'b0;
      r_cvld  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_rdy   <= (w_state_nxt == IDLE);
      r_cvld  <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_in <= '0;
      r_k  <= '0;
      for (int j = 0; j < N_OUT; j++)
        r_acc[j] <= '0;
    end else if (w_in_fire) begin
      r_in <= input_48_rsc_dat;
      r_k  <= '0;
      for (int j = 0; j < N_OUT; j++)
        r_acc[j] <= '0;
    end else if (r_state == CALC) begin
      r_k <= r_k + 1'b1;
      for (int j = 0; j < N_OUT; j++)
        r_acc[j] <= w_acc_nxt[j];
    end
  end

  // result is registered off the final add so OUT holds it steady
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dat <= '0;
      r_vld <= 1'b0;
    end else if ((r_state == CALC) && w_last) begin
      r_dat <= w_dat_nxt;
      r_vld <= 1'b1;
    end else if (w_out_fire) begin
      r_vld <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_in_tri  <= 1'b0;
      r_out_tri <= 1'b0;
    end else begin
      r_in_tri  <= w_in_fire;
      r_out_tri <= w_out_fire;
    end
  end

  assign input_48_rsc_rdy               = r_rdy;
  assign input_48_rsc_triosy_lz         = r_in_tri;
  assign layer7_out_rsc_dat             = r_dat;
  assign layer7_out_rsc_vld             = r_vld;
  assign layer7_out_rsc_triosy_lz       = r_out_tri;

  assign const_size_in_1_rsc_dat        = 16'(N_IN);
  assign const_size_in_1_rsc_vld        = r_cvld;
  assign const_size_in_1_rsc_triosy_lz  = r_out_tri;
  assign const_size_out_1_rsc_dat       = 16'(N_OUT);
  assign const_size_out_1_rsc_vld       = r_cvld;
  assign const_size_out_1_rsc_triosy_lz = r_out_tri;

endmodule

// File: tb/tb_econ_v0_encoder.sv
// Scoreboard bench for econ_v0_encoder: directed
// corner vectors plus random vectors vs a mean/ReLU model.
module tb_econ_v0_encoder;

  localparam int W  = 18;
  localparam int NI = 48;
  localparam int NO = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic [NI*W-1:0]   in_dat;
  logic              in_vld;
  logic              in_rdy;
  logic              in_tri;
  logic [NO*W-1:0]   o_dat;
  logic              o_vld;
  logic              o_rdy;
  logic              o_tri;
  logic [15:0]       ci_dat;
  logic              ci_vld;
  logic              ci_tri;
  logic [15:0]       co_dat;
  logic              co_vld;
  logic              co_tri;

  econ_v0_encoder dut (
    .clk                            (clk),
    .rst                            (rst),
    .input_48_rsc_dat               (in_dat),
    .input_48_rsc_vld               (in_vld),
    .input_48_rsc_rdy               (in_rdy),
    .input_48_rsc_triosy_lz         (in_tri),
    .layer7_out_rsc_dat             (o_dat),
    .layer7_out_rsc_vld             (o_vld),
    .layer7_out_rsc_rdy             (o_rdy),
    .layer7_out_rsc_triosy_lz       (o_tri),
    .const_size_in_1_rsc_dat        (ci_dat),
    .const_size_in_1_rsc_vld        (ci_vld),
    .const_size_in_1_rsc_triosy_lz  (ci_tri),
    .const_size_out_1_rsc_dat       (co_dat),
    .const_size_out_1_rsc_vld       (co_vld),
    .const_size_out_1_rsc_triosy_lz (co_tri)
  );

  always #5 clk = ~clk;

  int unsigned     cyc = 0;
  int              checks = 0;
  int              errors = 0;
  logic [NO*W-1:0] exp_q[$];
  int unsigned     lat_q[$];
  bit              rand_bp = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  // Reference: floor of the group mean, clamped at zero.
  function automatic logic [NO*W-1:0] model(
      input logic [NI*W-1:0] v);
    logic [NO*W-1:0]   r;
    logic signed [W-1:0] e;
    int s;
    r = '0;
    for (int j = 0; j < NO; j++) begin
      s = 0;
      for (int i = 0; i < NI/NO; i++) begin
        e = v[(j*(NI/NO) + i)*W +: W];
        s += e;
      end
      r[j*W +: W] = (s < 0) ? '0 : W'(s / 16);
    end
    return r;
  endfunction

  // Monitor: triosy timing, hold-while-stalled, latency,
  // and data popped from the scoreboard at each handshake.
  bit              pend_in, pend_out, prev_vld;
  logic [NO*W-1:0] prev_dat;
  logic [NO*W-1:0] e_dat;
  int unsigned     a_cyc;

  always @(negedge clk) begin
    if (!rst) begin
      pend_in  = 0;
      pend_out = 0;
      prev_vld = 0;
    end else begin
      chk("in_triosy", 64'(in_tri), 64'(pend_in));
      chk("out_triosy", 64'(o_tri), 64'(pend_out));
      chk("ci_triosy", 64'(ci_tri), 64'(pend_out));
      chk("co_triosy", 64'(co_tri), 64'(pend_out));
      pend_in = in_vld && in_rdy;
      if (o_vld) begin
        chk("in_rdy_while_out", 64'(in_rdy), 64'd0);
        if (!prev_vld) begin
          if (lat_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_vld: got vld=1 expected none");
          end else begin
            a_cyc = lat_q.pop_front();
            chk("latency", 64'(cyc - a_cyc), 64'd17);
          end
        end else begin
          chk("hold_data", 64'(o_dat), 64'(prev_dat));
        end
        if (o_rdy) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out: got %0h expected none",
                     o_dat);
          end else begin
            e_dat = exp_q.pop_front();
            chk("out_data", 64'(o_dat), 64'(e_dat));
          end
        end
      end
      pend_out = o_vld && o_rdy;
      prev_vld = o_vld;
      prev_dat = o_dat;
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rand_bp) o_rdy = ($urandom_range(0, 3) != 0);
  end

  task automatic send(input logic [NI*W-1:0] v,
                      input logic [NO*W-1:0] e,
                      input bit track);
    int n;
    n = 0;
    @(posedge clk);
    #1;
    in_vld = 1'b1;
    in_dat = v;
    forever begin
      @(negedge clk);
      if (in_rdy) break;
      n++;
      if (n > 200) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: got rdy=0 expected rdy=1");
        in_vld = 1'b0;
        return;
      end
    end
    if (track) begin
      exp_q.push_back(e);
      lat_q.push_back(cyc);
    end
    @(posedge clk);
    #1;
    in_vld = 1'b0;
    in_dat = '0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || o_vld) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0",
               exp_q.size());
    end
  endtask

  task automatic reset_checks();
    chk("rst_in_rdy", 64'(in_rdy), 64'd0);
    chk("rst_out_vld", 64'(o_vld), 64'd0);
    chk("rst_out_dat", 64'(o_dat), 64'd0);
    chk("rst_ci_vld", 64'(ci_vld), 64'd0);
    chk("rst_co_vld", 64'(co_vld), 64'd0);
  endtask

  task automatic post_release_checks();
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("pre_edge_rdy", 64'(in_rdy), 64'd0);
    @(negedge clk);
    chk("rel_in_rdy", 64'(in_rdy), 64'd1);
    chk("rel_ci_vld", 64'(ci_vld), 64'd1);
    chk("rel_co_vld", 64'(co_vld), 64'd1);
    chk("ci_dat", 64'(ci_dat), 64'd48);
    chk("co_dat", 64'(co_dat), 64'd3);
  endtask

  logic [NI*W-1:0] v;
  int              n;

  initial begin
    rst    = 1'b0;
    in_vld = 1'b0;
    in_dat = '0;
    o_rdy  = 1'b1;
    repeat (3) @(negedge clk);
    reset_checks();
    repeat (2) @(negedge clk);
    post_release_checks();

    for (int i = 0; i < NI; i++) v[i*W +: W] = W'(1);
    send(v, {18'd1, 18'd1, 18'd1}, 1);
    drain();

    for (int i = 0; i < 16; i++) begin
      v[i*W +: W]        = W'(32);
      v[(16+i)*W +: W]   = W'(-5);
      v[(32+i)*W +: W]   = W'(i);
    end
    send(v, {18'd7, 18'd0, 18'd32}, 1);
    drain();

    for (int i = 0; i < 16; i++) begin
      v[i*W +: W]        = (i < 15) ? W'(1) : W'(0);
      v[(16+i)*W +: W]   = W'(16);
      v[(32+i)*W +: W]   = W'(-1);
    end
    send(v, {18'd0, 18'd16, 18'd0}, 1);
    drain();

    for (int i = 0; i < NI; i++) v[i*W +: W] = W'(131071);
    send(v, {18'd131071, 18'd131071, 18'd131071}, 1);
    drain();

    // backpressure: output stalled 10 cycles once valid
    o_rdy = 1'b0;
    for (int i = 0; i < NI; i++) v[i*W +: W] = W'(i * 100);
    send(v, model(v), 1);
    n = 0;
    while (!o_vld && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("bp_vld_seen", 64'(o_vld), 64'd1);
    repeat (10) @(negedge clk);
    chk("bp_in_rdy", 64'(in_rdy), 64'd0);
    @(posedge clk);
    #1;
    o_rdy = 1'b1;
    drain();

    // abort a vector with reset in the middle of CALC
    for (int i = 0; i < NI; i++) v[i*W +: W] = W'(7);
    send(v, '0, 0);
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    reset_checks();
    @(negedge clk);
    post_release_checks();
    repeat (20) @(negedge clk);
    chk("abort_no_vld", 64'(o_vld), 64'd0);
    for (int i = 0; i < NI; i++) v[i*W +: W] = W'(3 * i);
    send(v, model(v), 1);
    drain();

    rand_bp = 1;
    for (int t = 0; t < 25; t++) begin
      for (int i = 0; i < NI; i++) begin
        unique case (t % 3)
          0: v[i*W +: W] = W'($urandom);
          1: v[i*W +: W] = W'($urandom_range(0, 131071));
          default: v[i*W +: W] = W'($urandom_range(0, 400))
                                 - W'(180);
        endcase
      end
      send(v, model(v), 1);
    end
    rand_bp = 0;
    @(posedge clk);
    #2;
    o_rdy = 1'b1;
    drain();
    repeat (3) @(negedge clk);
    chk("lat_q_empty", 64'(lat_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/econ_v0_encoder.md
Name: econ_v0_encoder

Overview:
- Streaming encoder stage for the ECON front end.
- Takes one 48-element feature vector and produces a 3-element latent vector.
- Each latent value is the ReLU of the floored mean of a 16-element slice of the input.
- Uses valid/ready handshakes on input and output, constant size outputs, and per-transaction "triosy" done strobes.

Parameters:
- W, 18, bit width of each signed input and output element.
- N_IN, 48, number of input elements.
- N_OUT, 3, number of output elements; each group holds N_IN/N_OUT = 16 elements.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- input_48_rsc_dat  in  864  packed input; element i = bits [18i+17:18i], signed two's complement.
- input_48_rsc_vld  in  1  input valid.
- input_48_rsc_rdy  out  1  input ready.
- input_48_rsc_triosy_lz  out  1  one-cycle strobe: input transaction done.
- layer7_out_rsc_dat  out  54  packed output; element j = bits [18j+17:18j], signed.
- layer7_out_rsc_vld  out  1  output valid.
- layer7_out_rsc_rdy  in  1  output ready.
- layer7_out_rsc_triosy_lz  out  1  one-cycle strobe: output transaction done.
- const_size_in_1_rsc_dat  out  16  constant 48.
- const_size_in_1_rsc_vld  out  1  constant-valid.
- const_size_in_1_rsc_triosy_lz  out  1  strobe, same timing as the output triosy.
- const_size_out_1_rsc_dat  out  16  constant 3.
- const_size_out_1_rsc_vld  out  1  constant-valid.
- const_size_out_1_rsc_triosy_lz  out  1  strobe, same timing as the output triosy.

Behaviour:
- Reset (rst=0, asynchronous) clears the following:
  - state forced to IDLE.
  - input_48_rsc_rdy=0, layer7_out_rsc_vld=0, layer7_out_rsc_dat=0.
  - all triosy=0.
  - const *_vld=0, counter=0, accumulators=0.
  - const *_dat are hard-wired 48 and 3 at all times.
- The first rising edge after rst releases sets const *_vld=1; they stay 1 until the next reset.
- States: IDLE, CALC, OUT.
- IDLE:
  - rdy=1.
  - On vld&&rdy at an edge: register the 864-bit input, clear the three 22-bit signed accumulators, set counter k=0, pulse input triosy high for the next cycle, go to CALC.
- CALC (rdy=0):
  - Each cycle, for each group j, acc[j] += element(16j+k), sign-extended.
  - k increments each cycle; after the k=15 add, go to OUT.
  - CALC lasts exactly 16 cycles.
- OUT:
  - layer7_out_rsc_dat[j] = (acc[j] < 0) ? 0 : acc[j] >>> 4, i.e. floor(sum/16), fits in 18 bits and is never saturated.
  - vld=1; data is held stable while vld=1 and rdy=0.
  - On vld&&rdy at an edge: vld drops, output and both const triosy pulse high for exactly one cycle, return to IDLE.
- Latency: input accept edge to vld high is 17 edges.
- Throughput: one vector per 18 cycles minimum (accept edge + 16 CALC + output handshake edge).
- Input vld is ignored outside IDLE; no input is captured until the output handshake completes.
- Output handshake and next-input acceptance never happen in the same cycle.
- Reset mid-CALC or mid-OUT aborts the vector. No output and no triosy are produced for it.

Test Plan:
- Reset held low 5 cycles, then released:
  - During reset: rdy=0, vld=0, const vld=0.
  - After the first edge post-release: rdy=1, const vld=1, const_size_in=48, const_size_out=3.
- All 48 elements = 1, out rdy=1:
  - Output {18'd1,18'd1,18'd1} with vld rising 17 edges after accept.
  - layer7 and const triosy pulse once.
- Group0 all 32, group1 all -5, group2 elements = 0..15 (sum 120):
  - Output elements: out0=32, out1=0 (ReLU), out2=7 (floor 7.5).
- Group0 fifteen 1s and one 0 (sum 15):
  - out0=0, confirming floor.
- Max positive: all 131071:
  - Out = 131071 per element, no overflow.
- Backpressure: out rdy=0 for 10 cycles, then 1:
  - vld and data held stable the whole time; input rdy stays 0.
  - Single triosy pulse on release.
- Reset mid-CALC (cycle 8):
  - No vld and no triosy for that vector.
  - A new vector is accepted normally afterwards.
